// File: rtl/vertex_smooth.sv
// Loop even-vertex repositioning: new_v = alpha(n)*v + beta(n)*sum(neighbours), per component.
// Reads positions from RAM_OBJ and adjacency from RAM_NBR, writes results to RAM_OUT.
// All state changes on the falling clock edge; the RAMs sample on the rising edge, so an
// address loaded at the end of one state returns its data by the end of the next state.
module vertex_smooth #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH         = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           RAM_OBJ_Do,
    output logic                  RAM_OBJ_EN,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [31:0]           RAM_OBJ_Di,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_NBR_EN,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [3:0]            RAM_NBR_WE,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  RAM_OUT_EN,
    output logic [ADDR_WIDTH-1:0] RAM_OUT_A,
    output logic [3:0]            RAM_OUT_WE,
    output logic [31:0]           RAM_OUT_Di,
    output logic                  busy,
    output logic                  done
);

    // Largest neighbour count honoured; the count word is clamped to this.
    localparam logic [3:0] N_MAX = 4'(MAX_NEIGHBOR_COUNT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_CNT, S_RD_IDX, S_RD_NX, S_RD_NY, S_RD_NZ,
        S_RD_SX, S_RD_SY, S_RD_SZ, S_CALC, S_WR_X, S_WR_Y, S_WR_Z,
        S_NEXT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]            k_q, k_d;           // current vertex, 1-based
    logic [31:0]            vc_q, vc_d;         // vertex count latched at start
    logic [3:0]             slot_q, slot_d;     // neighbour slot being read, 1-based
    logic [3:0]             n_raw_q, n_raw_d;   // clamped slot count of this vertex
    logic [3:0]             n_eff_q, n_eff_d;   // neighbours actually accumulated
    logic [31:0]            idx_q, idx_d;       // neighbour vertex currently fetched
    logic signed [39:0]     acc_x_q, acc_x_d;
    logic signed [39:0]     acc_y_q, acc_y_d;
    logic signed [39:0]     acc_z_q, acc_z_d;
    logic signed [31:0]     self_x_q, self_x_d;
    logic signed [31:0]     self_y_q, self_y_d;
    logic signed [31:0]     self_z_q, self_z_d;
    logic [31:0]            res_y_q, res_y_d;
    logic [31:0]            res_z_q, res_z_d;

    logic                  obj_en_q, obj_en_d;
    logic [ADDR_WIDTH-1:0] obj_a_q, obj_a_d;
    logic                  nbr_en_q, nbr_en_d;
    logic [ADDR_WIDTH-1:0] nbr_a_q, nbr_a_d;
    logic                  out_en_q, out_en_d;
    logic [ADDR_WIDTH-1:0] out_a_q, out_a_d;
    logic [3:0]            out_we_q, out_we_d;
    logic [31:0]           out_di_q, out_di_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic signed [39:0]    obj_do_ext;
    logic [3:0]            n_clamp;
    logic                  idx_valid;

    assign obj_do_ext = {{8{RAM_OBJ_Do[31]}}, RAM_OBJ_Do};
    assign n_clamp    = (RAM_NBR_Do[3:0] > N_MAX) ? N_MAX : RAM_NBR_Do[3:0];
    assign idx_valid  = (RAM_NBR_Do != 32'd0) && (RAM_NBR_Do <= vc_q);

    // Beta weight in Q0.16 for a given effective neighbour count.
    function automatic logic signed [17:0] beta_lut(input logic [3:0] n);
        logic signed [17:0] b;
        case (n)
            4'd1:    b = 18'sd24576;
            4'd2:    b = 18'sd12288;
            4'd3:    b = 18'sd12288;
            4'd4:    b = 18'sd6144;
            4'd5:    b = 18'sd4915;
            4'd6:    b = 18'sd4096;
            4'd7:    b = 18'sd3511;
            4'd8:    b = 18'sd3072;
            4'd9:    b = 18'sd2731;
            default: b = 18'sd0;
        endcase
        return b;
    endfunction

    // Weighted blend of one component; a vertex without valid neighbours is copied.
    function automatic logic [31:0] smooth(input logic signed [31:0] self_c,
                                           input logic signed [39:0] sum_c,
                                           input logic [3:0]         n);
        logic signed [17:0] beta;
        logic signed [17:0] alpha;
        logic signed [63:0] prod;
        logic [31:0]        r;
        beta  = beta_lut(n);
        alpha = 18'sd65536 - $signed({14'd0, n}) * beta;
        prod  = 64'(alpha) * 64'(self_c) + 64'(beta) * 64'(sum_c);
        prod  = prod >>> 16;
        if (n == 4'd0)
            r = self_c;
        else
            r = prod[31:0];
        return r;
    endfunction

    // Position of component c of vertex m in RAM_OBJ.
    function automatic logic [ADDR_WIDTH-1:0] obj_addr(input logic [31:0] m, input logic [1:0] c);
        logic [31:0] t;
        t = 32'd2 + 32'd3 * (m - 32'd1) + {30'd0, c};
        return t[ADDR_WIDTH-1:0];
    endfunction

    // Word `slot` of the adjacency block of vertex m in RAM_NBR.
    function automatic logic [ADDR_WIDTH-1:0] nbr_addr(input logic [31:0] m, input logic [3:0] slot);
        logic [31:0] t;
        t = (m - 32'd1) * 32'(MAX_NEIGHBOR_COUNT) + {28'd0, slot};
        return t[ADDR_WIDTH-1:0];
    endfunction

    // Result location of component c of vertex m in RAM_OUT.
    function automatic logic [ADDR_WIDTH-1:0] out_addr(input logic [31:0] m, input logic [1:0] c);
        logic [31:0] t;
        t = 32'd3 * (m - 32'd1) + {30'd0, c};
        return t[ADDR_WIDTH-1:0];
    endfunction

    // Next-state and next-output logic; each state loads the address whose data the next state consumes.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        vc_d     = vc_q;
        slot_d   = slot_q;
        n_raw_d  = n_raw_q;
        n_eff_d  = n_eff_q;
        idx_d    = idx_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        acc_z_d  = acc_z_q;
        self_x_d = self_x_q;
        self_y_d = self_y_q;
        self_z_d = self_z_q;
        res_y_d  = res_y_q;
        res_z_d  = res_z_q;
        obj_en_d = 1'b0;
        obj_a_d  = obj_a_q;
        nbr_en_d = 1'b0;
        nbr_a_d  = nbr_a_q;
        out_en_d = 1'b0;
        out_a_d  = out_a_q;
        out_we_d = 4'b0000;
        out_di_d = out_di_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vc_d = vertex_count;
                    if (vertex_count == 32'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        k_d      = 32'd1;
                        nbr_a_d  = nbr_addr(32'd1, 4'd0);
                        nbr_en_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = S_RD_CNT;
                    end
                end
            end
            S_RD_CNT: begin
                n_raw_d = n_clamp;
                n_eff_d = 4'd0;
                acc_x_d = '0;
                acc_y_d = '0;
                acc_z_d = '0;
                if (n_clamp == 4'd0) begin
                    obj_a_d  = obj_addr(k_q, 2'd0);
                    obj_en_d = 1'b1;
                    state_d  = S_RD_SX;
                end else begin
                    slot_d   = 4'd1;
                    nbr_a_d  = nbr_addr(k_q, 4'd1);
                    nbr_en_d = 1'b1;
                    state_d  = S_RD_IDX;
                end
            end
            S_RD_IDX: begin
                if (idx_valid) begin
                    idx_d    = RAM_NBR_Do;
                    obj_a_d  = obj_addr(RAM_NBR_Do, 2'd0);
                    obj_en_d = 1'b1;
                    state_d  = S_RD_NX;
                end else if (slot_q < n_raw_q) begin
                    slot_d   = slot_q + 4'd1;
                    nbr_a_d  = nbr_addr(k_q, slot_q + 4'd1);
                    nbr_en_d = 1'b1;
                end else begin
                    obj_a_d  = obj_addr(k_q, 2'd0);
                    obj_en_d = 1'b1;
                    state_d  = S_RD_SX;
                end
            end
            S_RD_NX: begin
                acc_x_d  = acc_x_q + obj_do_ext;
                obj_a_d  = obj_addr(idx_q, 2'd1);
                obj_en_d = 1'b1;
                state_d  = S_RD_NY;
            end
            S_RD_NY: begin
                acc_y_d  = acc_y_q + obj_do_ext;
                obj_a_d  = obj_addr(idx_q, 2'd2);
                obj_en_d = 1'b1;
                state_d  = S_RD_NZ;
            end
            S_RD_NZ: begin
                acc_z_d = acc_z_q + obj_do_ext;
                n_eff_d = n_eff_q + 4'd1;
                if (slot_q < n_raw_q) begin
                    slot_d   = slot_q + 4'd1;
                    nbr_a_d  = nbr_addr(k_q, slot_q + 4'd1);
                    nbr_en_d = 1'b1;
                    state_d  = S_RD_IDX;
                end else begin
                    obj_a_d  = obj_addr(k_q, 2'd0);
                    obj_en_d = 1'b1;
                    state_d  = S_RD_SX;
                end
            end
            S_RD_SX: begin
                self_x_d = RAM_OBJ_Do;
                obj_a_d  = obj_addr(k_q, 2'd1);
                obj_en_d = 1'b1;
                state_d  = S_RD_SY;
            end
            S_RD_SY: begin
                self_y_d = RAM_OBJ_Do;
                obj_a_d  = obj_addr(k_q, 2'd2);
                obj_en_d = 1'b1;
                state_d  = S_RD_SZ;
            end
            S_RD_SZ: begin
                self_z_d = RAM_OBJ_Do;
                state_d  = S_CALC;
            end
            S_CALC: begin
                res_y_d  = smooth(self_y_q, acc_y_q, n_eff_q);
                res_z_d  = smooth(self_z_q, acc_z_q, n_eff_q);
                out_di_d = smooth(self_x_q, acc_x_q, n_eff_q);
                out_a_d  = out_addr(k_q, 2'd0);
                out_en_d = 1'b1;
                out_we_d = 4'b1111;
                state_d  = S_WR_X;
            end
            S_WR_X: begin
                out_di_d = res_y_q;
                out_a_d  = out_addr(k_q, 2'd1);
                out_en_d = 1'b1;
                out_we_d = 4'b1111;
                state_d  = S_WR_Y;
            end
            S_WR_Y: begin
                out_di_d = res_z_q;
                out_a_d  = out_addr(k_q, 2'd2);
                out_en_d = 1'b1;
                out_we_d = 4'b1111;
                state_d  = S_WR_Z;
            end
            S_WR_Z: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (k_q == vc_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    k_d      = k_q + 32'd1;
                    nbr_a_d  = nbr_addr(k_q + 32'd1, 4'd0);
                    nbr_en_d = 1'b1;
                    state_d  = S_RD_CNT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs advance on the falling edge; reset aborts at once.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            vc_q     <= '0;
            slot_q   <= '0;
            n_raw_q  <= '0;
            n_eff_q  <= '0;
            idx_q    <= '0;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            acc_z_q  <= '0;
            self_x_q <= '0;
            self_y_q <= '0;
            self_z_q <= '0;
            res_y_q  <= '0;
            res_z_q  <= '0;
            obj_en_q <= 1'b0;
            obj_a_q  <= '0;
            nbr_en_q <= 1'b0;
            nbr_a_q  <= '0;
            out_en_q <= 1'b0;
            out_a_q  <= '0;
            out_we_q <= '0;
            out_di_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            vc_q     <= vc_d;
            slot_q   <= slot_d;
            n_raw_q  <= n_raw_d;
            n_eff_q  <= n_eff_d;
            idx_q    <= idx_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            acc_z_q  <= acc_z_d;
            self_x_q <= self_x_d;
            self_y_q <= self_y_d;
            self_z_q <= self_z_d;
            res_y_q  <= res_y_d;
            res_z_q  <= res_z_d;
            obj_en_q <= obj_en_d;
            obj_a_q  <= obj_a_d;
            nbr_en_q <= nbr_en_d;
            nbr_a_q  <= nbr_a_d;
            out_en_q <= out_en_d;
            out_a_q  <= out_a_d;
            out_we_q <= out_we_d;
            out_di_q <= out_di_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign RAM_OBJ_EN = obj_en_q;
    assign RAM_OBJ_A  = obj_a_q;
    assign RAM_OBJ_WE = 4'b0000;
    assign RAM_OBJ_Di = 32'd0;
    assign RAM_NBR_EN = nbr_en_q;
    assign RAM_NBR_A  = nbr_a_q;
    assign RAM_NBR_WE = 4'b0000;
    assign RAM_NBR_Di = 32'd0;
    assign RAM_OUT_EN = out_en_q;
    assign RAM_OUT_A  = out_a_q;
    assign RAM_OUT_WE = out_we_q;
    assign RAM_OUT_Di = out_di_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
